// File: rtl/code_seq_pkg.sv
// Shared state encoding and code constants for the code sequence monitor.
package code_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_HIGH   = 3'd2,
        ST_ZEROS  = 3'd3,
        ST_LOCKED = 3'd4
    } state_e;

    localparam logic [2:0] CODE_START = 3'b101;
    localparam logic [2:0] CODE_HIGH  = 3'b111;
    localparam logic [2:0] CODE_ZERO  = 3'b000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear together with an
// increment leaves the count at one so that event is not lost.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? WIDTH'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/code_seq_monitor.sv
// Watches a 3-bit code stream for 101, 111, then ZERO_RUN x 000 and reports
// lock, completion pulses, violation pulses and a saturating violation count.
module code_seq_monitor
    import code_seq_pkg::*;
#(
    parameter int unsigned ZERO_RUN = 4,
    parameter int unsigned ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       code_in,
    input  logic             code_valid,
    input  logic             cnt_clr,
    output logic             locked,
    output logic             seq_done,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt,
    output logic [2:0]       state
);

    localparam logic [3:0] RUN_TARGET = 4'(ZERO_RUN);

    state_e     state_q, state_d;
    logic [3:0] run_q, run_d;
    logic       locked_q, locked_d;
    logic       seq_done_q, seq_done_d;
    logic       err_q, err_d;

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        seq_done_d = 1'b0;
        err_d      = 1'b0;
        if (code_valid) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (code_in == CODE_START) state_d = ST_START;
                end
                ST_START: begin
                    if (code_in == CODE_HIGH) begin
                        state_d = ST_HIGH;
                    end else if (code_in != CODE_START) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (code_in == CODE_ZERO) begin
                        if (RUN_TARGET == 4'd1) begin
                            state_d    = ST_LOCKED;
                            seq_done_d = 1'b1;
                        end else begin
                            state_d = ST_ZEROS;
                            run_d   = 4'd1;
                        end
                    end else begin
                        state_d = (code_in == CODE_START) ? ST_START : ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
                ST_ZEROS: begin
                    // run is cleared on every way out of ZEROS
                    if (code_in == CODE_ZERO) begin
                        if (4'(run_q + 4'd1) == RUN_TARGET) begin
                            state_d    = ST_LOCKED;
                            seq_done_d = 1'b1;
                            run_d      = '0;
                        end else begin
                            run_d = 4'(run_q + 4'd1);
                        end
                    end else begin
                        state_d = (code_in == CODE_START) ? ST_START : ST_IDLE;
                        err_d   = 1'b1;
                        run_d   = '0;
                    end
                end
                ST_LOCKED: begin
                    if (code_in == CODE_START) begin
                        state_d = ST_START;
                    end else if (code_in != CODE_ZERO) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    run_d   = '0;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            run_q      <= '0;
            locked_q   <= 1'b0;
            seq_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            locked_q   <= locked_d;
            seq_done_q <= seq_done_d;
            err_q      <= err_d;
        end
    end

    sat_counter #(
        .WIDTH(ERR_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (err_d),
        .clr  (cnt_clr),
        .count(err_cnt)
    );

    assign locked   = locked_q;
    assign seq_done = seq_done_q;
    assign err      = err_q;
    assign state    = state_q;

endmodule
